hight_key_sched: RTL and testbench
==================================

// Module: hight_key_sched
// PURPOSE
//  HIGHT key schedule, upstream of the round-function stage.
//  On start it captures the 128-bit master key and the enc/dec mode, and expands all 128 subkeys into a local buffer in 32 cycles.
//  It then streams 4 subkeys per round (32 rounds) under a valid/adv handshake, presenting the initial and final whitening keys in the matching phases.
// PARAMETERS
//  NRND      32     rounds streamed (fixed by HIGHT; SK count = 4*NRND)
//  DELTA0    8'h5A  LFSR seed, delta[0] (7-bit value, bit7 always 0)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  reset    in   1    asynchronous, active-low reset (0 clears state)
//  start    in   1    one-cycle request; sampled only in IDLE
//  ed       in   1    1=encrypt, 0=decrypt; captured with start
//  MK       in   128  master key; byte MK_k = MK[8k+7:8k], k=0..15
//  adv      in   1    consumer accepts current subkey set
//  busy     out  1    high in any state other than IDLE
//  sk_valid out  1    SKx0..SKx3 hold a valid round set
//  rnd      out  5    index of the round currently presented, 0..31
//  SKx0..SKx3 out 8 each  round subkeys
//  WK0_4,WK1_5,WK2_6,WK3_7 out 8 each  whitening keys for current phase
//  done     out  1    one-cycle pulse when the final whitening keys appear
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; subkey buffer contents don't-care.
//  States: IDLE -> GEN -> RUN -> FIN -> IDLE.
//  - IDLE: start=1 latches MK, ed, and lfsr=DELTA0; gen_cnt=0; go GEN next cycle.
//  - GEN (32 cycles, c=0..31):
//    - writes SK[4c..4c+3]; for k=16i+j (j<8), SK[k] = MK_((j-i) mod 8) + delta[k].
//    - SK[k+8] = MK_(((j-i) mod 8)+8) + delta[k+8]; i=c>>2, half=(c>>1)&1, j0=(c&1)*4.
//    - delta[n+1] = {1'b0, d[3]^d[0], d[6:1]}; the LFSR advances 4 steps per cycle (unrolled).
//    - All adds are mod 256 (carry discarded).
//    - Moves to RUN after c=31; rnd=0.
//  - RUN: sk_valid=1.
//    - ed=1: SKx0..3 = SK[4r], SK[4r+1], SK[4r+2], SK[4r+3].
//    - ed=0: SKx0..3 = SK[4q+3], SK[4q+2], SK[4q+1], SK[4q], with q=31-r.
//    - adv=1 advances r on the next edge; adv=0 holds all outputs stable.
//    - adv while r=31 moves to FIN; sk_valid drops in the same edge.
//  - FIN: one cycle; done=1; SK outputs hold the last set; then IDLE (WK outputs keep the final value).
//  Whitening (WKi = MK_(i+12) for i=0..3; WK(i+4) = MK_i):
//    - ed=1: initial = WK0..3 (GEN, RUN); final = WK4..7 (FIN, IDLE after).
//    - ed=0: initial = WK4..7; final = WK0..3.
//  Latency: start to first sk_valid = 33 cycles; minimum start to done = 33+32 = 65 cycles.
//  Boundary conditions:
//    - start while busy is ignored; a change of MK or ed while busy has no effect.
//    - adv while sk_valid=0 is ignored.
//    - start and adv in the same IDLE cycle: start wins.
//    - reset low mid-run returns to IDLE immediately; sk_valid and done go low asynchronously.
// TESTING
//  1 MK=0, ed=1, start, adv held 1 -> after 33 cycles sk_valid=1 with SKx0..3=5A,6D,36,1B; rnd 0..31; done 32 cycles later.
//  2 MK=0, ed=0 -> first set SKx0..3 = SK127,SK126,SK125,SK124 (match model deltas 124..127); last set = 1B,36,6D,5A.
//  3 MK=0x00112233445566778899AABBCCDDEEFF, ed=1:
//    - initial WK0_4..WK3_7 = 33,22,11,00;
//    - final = FF,EE,DD,CC;
//    - the full 128-SK stream matches the C reference model.
//  4 adv toggled pseudo-randomly during RUN -> outputs stable while adv=0; exactly 32 accepted sets; no skipped or duplicated rnd.
//  5 reset driven low at rnd=10 -> busy/sk_valid = 0 at once; new start gives a correct full stream.
//  6 start pulsed during GEN and RUN -> ignored; stream is unchanged versus an undisturbed run.

Source files
------------

// File: rtl/hight_key_sched_if.sv
// Handshake and key bus between the HIGHT key schedule and its round-function consumer.
interface hight_key_sched_if;
  logic         start;
  logic         ed;
  logic [127:0] MK;
  logic         adv;
  logic         busy;
  logic         sk_valid;
  logic [4:0]   rnd;
  logic [7:0]   SKx0;
  logic [7:0]   SKx1;
  logic [7:0]   SKx2;
  logic [7:0]   SKx3;
  logic [7:0]   WK0_4;
  logic [7:0]   WK1_5;
  logic [7:0]   WK2_6;
  logic [7:0]   WK3_7;
  logic         done;

  modport master (
    output start, ed, MK, adv,
    input  busy, sk_valid, rnd, SKx0, SKx1, SKx2, SKx3,
           WK0_4, WK1_5, WK2_6, WK3_7, done
  );

  modport slave (
    input  start, ed, MK, adv,
    output busy, sk_valid, rnd, SKx0, SKx1, SKx2, SKx3,
           WK0_4, WK1_5, WK2_6, WK3_7, done
  );
endinterface

// File: rtl/hight_key_sched.sv
// HIGHT key schedule: expands 128 subkeys in 32 cycles, then streams 4 per round; first set 33 cycles after start.
// The consumer paces the stream with adv; without adv every output holds.
module hight_key_sched #(
  parameter int         NRND   = 32,
  parameter logic [7:0] DELTA0 = 8'h5A
) (
  input logic              clk,
  input logic              reset,
  hight_key_sched_if.slave kif
);
  localparam logic [4:0] LAST = 5'(NRND - 1);

  typedef enum logic [1:0] {IDLE, GEN, RUN, FIN} state_t;

  state_t       state, state_nxt;
  logic [127:0] mk_q;
  logic         ed_q;
  logic [6:0]   lfsr, lfsr_nxt;
  logic [4:0]   gen_cnt, rnd_q, rd_idx;
  logic [31:0]  sk_mem [NRND];
  logic [31:0]  gen_word, rd_word, wk_fwd, wk_rev;
  logic [6:0]   d;
  logic [2:0]   jm;
  logic [3:0]   b;
  logic         show, wk_init;

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[3] ^ v[0], v[6:1]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kif.start) state_nxt = GEN;
      GEN:     if (gen_cnt == LAST) state_nxt = RUN;
      RUN:     if (kif.adv && rnd_q == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    kif.busy     = (state != IDLE);
    kif.sk_valid = (state == RUN);
    kif.done     = (state == FIN);
    show         = (state == RUN) || (state == FIN);
    wk_init      = (state == GEN) || (state == RUN);
  end

  // Cycle c covers SK[4c..4c+3]: bit1 of c picks the upper key half, bit0 the j offset.
  always_comb begin
    gen_word = '0;
    d        = lfsr;
    jm       = '0;
    b        = '0;
    for (int t = 0; t < 4; t++) begin
      jm = 3'({gen_cnt[0], 2'(t)} - gen_cnt[4:2]);
      b  = {gen_cnt[1], jm};
      gen_word[8*t +: 8] = mk_q[{b, 3'b000} +: 8] + {1'b0, d};
      d  = lfsr_step(d);
    end
    lfsr_nxt = d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mk_q    <= '0;
      ed_q    <= 1'b0;
      lfsr    <= '0;
      gen_cnt <= '0;
      rnd_q   <= '0;
    end else begin
      case (state)
        IDLE: if (kif.start) begin
          mk_q    <= kif.MK;
          ed_q    <= kif.ed;
          lfsr    <= DELTA0[6:0];
          gen_cnt <= '0;
          rnd_q   <= '0;
        end
        GEN: begin
          lfsr    <= lfsr_nxt;
          gen_cnt <= gen_cnt + 5'd1;
        end
        RUN: if (kif.adv && rnd_q != LAST) rnd_q <= rnd_q + 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == GEN) sk_mem[gen_cnt] <= gen_word;
  end

  // Decryption walks the buffer backwards and reverses the order within each set.
  assign rd_idx   = ed_q ? rnd_q : LAST - rnd_q;
  assign rd_word  = sk_mem[rd_idx];
  assign kif.rnd  = rnd_q;
  assign kif.SKx0 = !show ? 8'h00 : (ed_q ? rd_word[7:0]   : rd_word[31:24]);
  assign kif.SKx1 = !show ? 8'h00 : (ed_q ? rd_word[15:8]  : rd_word[23:16]);
  assign kif.SKx2 = !show ? 8'h00 : (ed_q ? rd_word[23:16] : rd_word[15:8]);
  assign kif.SKx3 = !show ? 8'h00 : (ed_q ? rd_word[31:24] : rd_word[7:0]);

  assign wk_fwd = {mk_q[103:96], mk_q[111:104], mk_q[119:112], mk_q[127:120]};
  assign wk_rev = {mk_q[7:0], mk_q[15:8], mk_q[23:16], mk_q[31:24]};
  assign {kif.WK0_4, kif.WK1_5, kif.WK2_6, kif.WK3_7} = (wk_init == ed_q) ? wk_fwd : wk_rev;
endmodule

// File: tb/tb_hight_key_sched.sv
// Directed vector bench for hight_key_sched: table of keys/modes plus reset-abort and start-while-busy sequences.
module tb_hight_key_sched;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hight_key_sched_if kif ();

  hight_key_sched dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  typedef struct {
    logic [127:0] mk;
    logic         ed;
    logic [31:0]  first;
    logic [31:0]  last;
    logic [31:0]  wki;
    logic [31:0]  wkf;
    int           mode;   // 0: adv held high, 1: random adv, 2: start pulses while busy
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] exp_sk [128];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_model(input logic [127:0] mk);
    logic [6:0] dl;
    logic [7:0] delta [128];
    int         m;
    dl = 7'h5A;
    for (int n = 0; n < 128; n++) begin
      delta[n] = {1'b0, dl};
      dl = {dl[3] ^ dl[0], dl[6:1]};
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m = (j - i + 8) % 8;
        exp_sk[16*i+j]   = 8'(mk[8*m +: 8] + delta[16*i+j]);
        exp_sk[16*i+j+8] = 8'(mk[8*(m+8) +: 8] + delta[16*i+j+8]);
      end
    end
  endfunction

  function automatic logic [31:0] exp_set(input int r, input logic ed);
    int q;
    if (ed) return {exp_sk[4*r], exp_sk[4*r+1], exp_sk[4*r+2], exp_sk[4*r+3]};
    q = 31 - r;
    return {exp_sk[4*q+3], exp_sk[4*q+2], exp_sk[4*q+1], exp_sk[4*q]};
  endfunction

  function automatic logic [31:0] sk_bus();
    return {kif.SKx0, kif.SKx1, kif.SKx2, kif.SKx3};
  endfunction

  function automatic logic [31:0] wk_bus();
    return {kif.WK0_4, kif.WK1_5, kif.WK2_6, kif.WK3_7};
  endfunction

  task automatic run_vec(input vec_t v, input int abort_at);
    int          lat, cyc, acc;
    logic        a;
    logic [31:0] got;
    build_model(v.mk);
    @(negedge clk);
    kif.MK    = v.mk;
    kif.ed    = v.ed;
    kif.start = 1'b1;
    kif.adv   = (v.mode != 1);   // adv alongside start must not matter
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      kif.start = (v.mode == 2 && lat == 5);
      if (kif.start) begin
        kif.MK = ~v.mk;
        kif.ed = ~v.ed;
      end
      if (v.mode == 1) kif.adv = 1'($urandom_range(0, 1));
      if (lat == 1) begin
        check("busy_gen", kif.busy, 1);
        check("wk_init_gen", wk_bus(), v.wki);
      end
    end while (!kif.sk_valid && lat < 40);
    check("start_to_valid", lat, 33);

    cyc = lat;
    acc = 0;
    while (acc < 32 && cyc < lat + 400 && kif.sk_valid) begin
      got = sk_bus();
      check("sk_set", got, exp_set(acc, v.ed));
      check("rnd", kif.rnd, acc);
      if (acc == 0) begin
        check("first_set_table", got, v.first);
        check("wk_init_run", wk_bus(), v.wki);
      end
      if (acc == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_busy", kif.busy, 0);
        check("abort_valid", kif.sk_valid, 0);
        check("abort_done", kif.done, 0);
        check("abort_sk", sk_bus(), 0);
        kif.adv   = 1'b0;
        kif.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      a = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      kif.adv   = a;
      kif.start = (v.mode == 2 && acc == 7);
      @(negedge clk);
      cyc++;
      if (a) acc++;
    end
    kif.start = 1'b0;
    kif.adv   = 1'b0;
    check("accepted_sets", acc, 32);
    check("done_pulse", kif.done, 1);
    check("valid_drop", kif.sk_valid, 0);
    check("last_set_hold", sk_bus(), v.last);
    check("wk_final", wk_bus(), v.wkf);
    if (v.mode != 1) check("start_to_done", cyc, 65);
    @(negedge clk);
    check("done_once", kif.done, 0);
    check("idle_busy", kif.busy, 0);
    check("wk_final_idle", wk_bus(), v.wkf);
  endtask

  initial begin
    vecs[0] = '{128'h0, 1'b1, 32'h5A6D361B, 32'h576B355A, 32'h0, 32'h0, 0};
    vecs[1] = '{128'h0, 1'b0, 32'h5A356B57, 32'h1B366D5A, 32'h0, 32'h0, 0};
    vecs[2] = '{128'h00112233445566778899AABBCCDDEEFF, 1'b1, 32'h595B13E7, 32'h797C35D1,
                32'h33221100, 32'hFFEEDDCC, 0};
    vecs[3] = '{128'h00112233445566778899AABBCCDDEEFF, 1'b0, 32'hD1357C79, 32'hE7135B59,
                32'hFFEEDDCC, 32'h33221100, 1};
    vecs[4] = '{{128{1'b1}}, 1'b1, 32'h596C351A, 32'h566A3459, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};

    kif.start = 1'b0;
    kif.adv   = 1'b0;
    kif.ed    = 1'b0;
    kif.MK    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", kif.busy, 0);
    check("rst_valid", kif.sk_valid, 0);
    check("rst_done", kif.done, 0);
    check("rst_rnd", kif.rnd, 0);
    check("rst_sk", sk_bus(), 0);
    check("rst_wk", wk_bus(), 0);
    reset = 1'b1;
    kif.adv = 1'b1;
    @(negedge clk);
    check("idle_adv_ignored", kif.busy, 0);
    kif.adv = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], -1);

    // Reset mid-stream, then a fresh start must give the full stream again.
    run_vec(vecs[2], 10);
    check("post_abort_idle", kif.busy, 0);
    run_vec(vecs[2], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
